// File: rtl/pkt_field_parser_pkg.sv
// ----------------------------------------------------------------------------
// pkt_field_parser_pkg
// Shared definitions for the receive-side packet field parser:
//   - packet type codes (HB, CHE, TS, DATA, SOS, NONE)
//   - word index of every field inside a packet
//   - minimum legal packet length per type
//   - broadcast destination ID
//   - parser FSM state type
//   - helpers: min_len(), is_known(), has_dest()
// ----------------------------------------------------------------------------
package pkt_field_parser_pkg;

   // Packet type codes carried in header bits [15:13]
   localparam logic [2:0] PT_HB   = 3'b000;
   localparam logic [2:0] PT_CHE  = 3'b001;
   localparam logic [2:0] PT_TS   = 3'b100;
   localparam logic [2:0] PT_DATA = 3'b101;
   localparam logic [2:0] PT_SOS  = 3'b110;
   localparam logic [2:0] PT_NONE = 3'b111;

   // Field word indices (word 0 is the header)
   localparam logic [7:0] IDX_SRC  = 8'd1;
   localparam logic [7:0] IDX_HOPS = 8'd2;
   localparam logic [7:0] IDX_EMAX = 8'd3;
   localparam logic [7:0] IDX_EMIN = 8'd4;
   localparam logic [7:0] IDX_ETH  = 8'd5;
   localparam logic [7:0] IDX_CH   = 8'd2;
   localparam logic [7:0] IDX_DEST = 8'd2;
   localparam logic [7:0] IDX_TS   = 8'd3;

   // Minimum total word count (header included) per type
   localparam logic [7:0] MINLEN_HB   = 8'd6;
   localparam logic [7:0] MINLEN_CHE  = 8'd3;
   localparam logic [7:0] MINLEN_TS   = 8'd4;
   localparam logic [7:0] MINLEN_DATA = 8'd3;
   localparam logic [7:0] MINLEN_SOS  = 8'd2;

   localparam logic [15:0] BROADCAST_ID = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIELDS,
      S_DRAIN,
      S_COMMIT,
      S_ERR
   } state_t;

   // Returns 0 for unknown types; callers must also check is_known().
   function automatic logic [7:0] min_len(input logic [2:0] t);
      case (t)
         PT_HB:   min_len = MINLEN_HB;
         PT_CHE:  min_len = MINLEN_CHE;
         PT_TS:   min_len = MINLEN_TS;
         PT_DATA: min_len = MINLEN_DATA;
         PT_SOS:  min_len = MINLEN_SOS;
         default: min_len = 8'd0;
      endcase
   endfunction

   function automatic logic is_known(input logic [2:0] t);
      is_known = (t == PT_HB) || (t == PT_CHE) || (t == PT_TS) ||
                 (t == PT_DATA) || (t == PT_SOS);
   endfunction

   // Types that carry a destination word subject to filtering
   function automatic logic has_dest(input logic [2:0] t);
      has_dest = (t == PT_TS) || (t == PT_DATA);
   endfunction

endpackage

// File: rtl/pkt_field_parser.sv
// ----------------------------------------------------------------------------
// pkt_field_parser
// Decodes 16-bit packet words from the radio RX FIFO, extracts the HB / CHE /
// TS / DATA / SOS fields, filters on destination and issues a one-cycle
// en_MNI commit to the node-info stage. Malformed, foreign and unknown
// packets are drained; malformed/unknown ones pulse pkt_err.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready   input word stream (valid/ready)
//   myNodeID           own node ID for destination filtering
//   en_MNI             one-cycle commit strobe
//   fPktType           committed type during en_MNI, 3'b111 otherwise
//   src_ID .. timeslot registered field outputs, held between commits
//   pkt_err            one-cycle pulse for a malformed/unknown packet
//
// Optional build macro PKT_STATS_EN adds saturating counters
//   cnt_ok (commits), cnt_err (pkt_err pulses), cnt_drop (silent drops).
// ----------------------------------------------------------------------------
module pkt_field_parser
   import pkt_field_parser_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int MAX_WORDS  = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   output logic                  en_MNI,
   output logic [2:0]            fPktType,
   output logic [WORD_WIDTH-1:0] src_ID,
   output logic [WORD_WIDTH-1:0] hops,
   output logic [WORD_WIDTH-1:0] e_max,
   output logic [WORD_WIDTH-1:0] e_min,
   output logic [WORD_WIDTH-1:0] e_threshold,
   output logic [WORD_WIDTH-1:0] ch_ID,
   output logic [WORD_WIDTH-1:0] timeslot,
   output logic                  pkt_err
`ifdef PKT_STATS_EN
   ,
   output logic [15:0]           cnt_ok,
   output logic [15:0]           cnt_err,
   output logic [15:0]           cnt_drop
`endif
);

   localparam logic [7:0]            MAX_LEN  = 8'(MAX_WORDS);
   localparam logic [WORD_WIDTH-1:0] FIELD_MX = '1;
   localparam logic [WORD_WIDTH-1:0] BCAST    = WORD_WIDTH'(BROADCAST_ID);

   state_t                state_q, state_d;
   logic [2:0]            type_q,  type_d;
   logic [7:0]            len_q,   len_d;
   logic [7:0]            idx_q,   idx_d;    // index of the word now on the bus
   logic                  err_q,   err_d;

   // Shadow registers filled while the packet streams in
   logic [WORD_WIDTH-1:0] src_sh_q,  src_sh_d;
   logic [WORD_WIDTH-1:0] hops_sh_q, hops_sh_d;
   logic [WORD_WIDTH-1:0] emax_sh_q, emax_sh_d;
   logic [WORD_WIDTH-1:0] emin_sh_q, emin_sh_d;
   logic [WORD_WIDTH-1:0] eth_sh_q,  eth_sh_d;
   logic [WORD_WIDTH-1:0] ch_sh_q,   ch_sh_d;
   logic [WORD_WIDTH-1:0] ts_sh_q,   ts_sh_d;

   // Committed output registers
   logic [WORD_WIDTH-1:0] src_q,  src_d;
   logic [WORD_WIDTH-1:0] hops_q, hops_d;
   logic [WORD_WIDTH-1:0] emax_q, emax_d;
   logic [WORD_WIDTH-1:0] emin_q, emin_d;
   logic [WORD_WIDTH-1:0] eth_q,  eth_d;
   logic [WORD_WIDTH-1:0] ch_q,   ch_d;
   logic [WORD_WIDTH-1:0] ts_q,   ts_d;

   logic xfer;
   logic foreign;
   logic commit_go;
   logic drop;

   assign in_ready = (state_q == S_IDLE) || (state_q == S_FIELDS) || (state_q == S_DRAIN);
   assign xfer     = in_valid && in_ready;

   // Destination is judged when the dest word itself is on the bus, so a
   // foreign packet can be drained without storing the dest word.
   assign foreign  = has_dest(type_q) && (idx_q == IDX_DEST) &&
                     (in_data != myNodeID) && (in_data != BCAST);

   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      len_d     = len_q;
      idx_d     = idx_q;
      err_d     = err_q;
      src_sh_d  = src_sh_q;
      hops_sh_d = hops_sh_q;
      emax_sh_d = emax_sh_q;
      emin_sh_d = emin_sh_q;
      eth_sh_d  = eth_sh_q;
      ch_sh_d   = ch_sh_q;
      ts_sh_d   = ts_sh_q;
      commit_go = 1'b0;
      drop      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               type_d = in_data[WORD_WIDTH-1 -: 3];
               len_d  = in_data[7:0];
               idx_d  = 8'd1;
               err_d  = 1'b0;
               if (in_last) begin
                  state_d = S_ERR;
               end else if (!is_known(type_d) || (len_d < min_len(type_d)) ||
                            (len_d > MAX_LEN)) begin
                  state_d = S_DRAIN;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_FIELDS;
               end
            end
         end

         S_FIELDS: begin
            if (xfer) begin
               idx_d = idx_q + 8'd1;
               if (idx_q >= len_q) begin
                  // Word past the advertised length
                  if (in_last) begin
                     state_d = S_ERR;
                  end else begin
                     state_d = S_DRAIN;
                     err_d   = 1'b1;
                  end
               end else begin
                  case (type_q)
                     PT_HB: begin
                        if (idx_q == IDX_SRC)  src_sh_d  = in_data;
                        if (idx_q == IDX_HOPS) hops_sh_d = in_data;
                        if (idx_q == IDX_EMAX) emax_sh_d = in_data;
                        if (idx_q == IDX_EMIN) emin_sh_d = in_data;
                        if (idx_q == IDX_ETH)  eth_sh_d  = in_data;
                     end
                     PT_CHE: begin
                        if (idx_q == IDX_SRC) src_sh_d = in_data;
                        if (idx_q == IDX_CH)  ch_sh_d  = in_data;
                     end
                     PT_TS: begin
                        if (idx_q == IDX_SRC) src_sh_d = in_data;
                        if (idx_q == IDX_TS)  ts_sh_d  = in_data;
                     end
                     default: begin   // DATA, SOS: only src is kept
                        if (idx_q == IDX_SRC) src_sh_d = in_data;
                     end
                  endcase

                  if (in_last) begin
                     if (idx_q != len_q - 8'd1) begin
                        state_d = S_ERR;
                     end else if (foreign) begin
                        state_d = S_IDLE;
                        drop    = 1'b1;
                     end else begin
                        state_d   = S_COMMIT;
                        commit_go = 1'b1;
                     end
                  end else if (foreign) begin
                     state_d = S_DRAIN;   // err_q stays clear: silent drop
                  end
               end
            end
         end

         S_DRAIN: begin
            if (xfer && in_last) begin
               if (err_q || !is_known(type_q)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_IDLE;
                  drop    = 1'b1;
               end
            end
         end

         S_COMMIT: state_d = S_IDLE;
         S_ERR:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs load on the final transfer edge from the updated shadows so
   // they are already stable during the en_MNI cycle.
   always_comb begin
      src_d  = src_q;
      hops_d = hops_q;
      emax_d = emax_q;
      emin_d = emin_q;
      eth_d  = eth_q;
      ch_d   = ch_q;
      ts_d   = ts_q;
      if (commit_go) begin
         src_d = src_sh_d;
         case (type_q)
            PT_HB: begin
               hops_d = (hops_sh_d == FIELD_MX) ? FIELD_MX : hops_sh_d + 1'b1;
               emax_d = emax_sh_d;
               emin_d = emin_sh_d;
               eth_d  = eth_sh_d;
            end
            PT_CHE:  ch_d = ch_sh_d;
            PT_TS:   ts_d = ts_sh_d;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         type_q    <= PT_NONE;
         len_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         src_sh_q  <= '0;
         hops_sh_q <= '0;
         emax_sh_q <= '0;
         emin_sh_q <= '0;
         eth_sh_q  <= '0;
         ch_sh_q   <= '0;
         ts_sh_q   <= '0;
         src_q     <= '0;
         hops_q    <= '0;
         emax_q    <= '0;
         emin_q    <= '0;
         eth_q     <= '0;
         ch_q      <= '0;
         ts_q      <= '0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         src_sh_q  <= src_sh_d;
         hops_sh_q <= hops_sh_d;
         emax_sh_q <= emax_sh_d;
         emin_sh_q <= emin_sh_d;
         eth_sh_q  <= eth_sh_d;
         ch_sh_q   <= ch_sh_d;
         ts_sh_q   <= ts_sh_d;
         src_q     <= src_d;
         hops_q    <= hops_d;
         emax_q    <= emax_d;
         emin_q    <= emin_d;
         eth_q     <= eth_d;
         ch_q      <= ch_d;
         ts_q      <= ts_d;
      end
   end

   assign en_MNI      = (state_q == S_COMMIT);
   assign pkt_err     = (state_q == S_ERR);
   assign fPktType    = en_MNI ? type_q : PT_NONE;
   assign src_ID      = src_q;
   assign hops        = hops_q;
   assign e_max       = emax_q;
   assign e_min       = emin_q;
   assign e_threshold = eth_q;
   assign ch_ID       = ch_q;
   assign timeslot    = ts_q;

`ifdef PKT_STATS_EN
   logic [15:0] cnt_ok_q,   cnt_ok_d;
   logic [15:0] cnt_err_q,  cnt_err_d;
   logic [15:0] cnt_drop_q, cnt_drop_d;

   always_comb begin
      cnt_ok_d   = cnt_ok_q;
      cnt_err_d  = cnt_err_q;
      cnt_drop_d = cnt_drop_q;
      if (en_MNI  && cnt_ok_q   != 16'hFFFF) cnt_ok_d   = cnt_ok_q   + 16'd1;
      if (pkt_err && cnt_err_q  != 16'hFFFF) cnt_err_d  = cnt_err_q  + 16'd1;
      if (drop    && cnt_drop_q != 16'hFFFF) cnt_drop_d = cnt_drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_ok_q   <= '0;
         cnt_err_q  <= '0;
         cnt_drop_q <= '0;
      end else begin
         cnt_ok_q   <= cnt_ok_d;
         cnt_err_q  <= cnt_err_d;
         cnt_drop_q <= cnt_drop_d;
      end
   end

   assign cnt_ok   = cnt_ok_q;
   assign cnt_err  = cnt_err_q;
   assign cnt_drop = cnt_drop_q;
`endif

endmodule

// File: tb/tb_pkt_field_parser.sv
module tb_pkt_field_parser;

   logic        clk = 1'b0;
   logic        nrst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [15:0] myNodeID;
   logic        en_MNI;
   logic [2:0]  fPktType;
   logic [15:0] src_ID, hops, e_max, e_min, e_threshold, ch_ID, timeslot;
   logic        pkt_err;
`ifdef PKT_STATS_EN
   logic [15:0] cnt_ok, cnt_err, cnt_drop;
`endif

   int nvec = 0;
   int nerr = 0;
   int en_cnt = 0;
   int perr_cnt = 0;

   always #5 clk = ~clk;

   pkt_field_parser dut (
      .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .myNodeID(myNodeID),
      .en_MNI(en_MNI), .fPktType(fPktType), .src_ID(src_ID), .hops(hops),
      .e_max(e_max), .e_min(e_min), .e_threshold(e_threshold),
      .ch_ID(ch_ID), .timeslot(timeslot), .pkt_err(pkt_err)
`ifdef PKT_STATS_EN
      , .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_drop(cnt_drop)
`endif
   );

   // Pulse counters used to confirm "no commit / no error" windows
   always @(posedge clk) begin
      if (nrst) begin
         if (en_MNI)  en_cnt++;
         if (pkt_err) perr_cnt++;
      end
   end

   // One word; returns #1 after the edge on which it transferred
   task automatic put(input logic [15:0] d, input logic l);
      int guard = 0;
      in_data = d; in_valid = 1'b1; in_last = l;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (!in_ready) begin
         nvec++; nerr++;
         $display("FAIL put_timeout: in_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] w[$], input int last_at, input int gap);
      for (int i = 0; i < w.size(); i++) begin
         put(w[i], i == last_at);
         if (gap > 0 && i != w.size() - 1) repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      nrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; myNodeID = 16'h000C;
      idle(3);
      nvec++; if (en_MNI !== 1'b0) begin nerr++; $display("FAIL rst_en: got %b want 0", en_MNI); end
      nvec++; if (fPktType !== 3'b111) begin nerr++; $display("FAIL rst_type: got %b want 111", fPktType); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", in_ready); end
      nvec++; if (pkt_err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b want 0", pkt_err); end
      nvec++; if ({src_ID, hops, e_max, e_min, e_threshold, ch_ID, timeslot} !== 112'h0) begin
         nerr++; $display("FAIL rst_fields: got %h want 0", {src_ID, hops, e_max, e_min, e_threshold, ch_ID, timeslot});
      end
      nrst = 1'b1;
      idle(1);
   endtask

   task automatic test_hb(input int gap);
      send_pkt('{16'h0006, 16'h0003, 16'h0002, 16'h0400, 16'h0100, 16'h0080}, 5, gap);
      nvec++; if (en_MNI !== 1'b1) begin nerr++; $display("FAIL hb_en gap%0d: got %b want 1", gap, en_MNI); end
      nvec++; if (fPktType !== 3'b000) begin nerr++; $display("FAIL hb_type: got %b want 000", fPktType); end
      nvec++; if (src_ID !== 16'h0003) begin nerr++; $display("FAIL hb_src: got %h want 0003", src_ID); end
      nvec++; if (hops !== 16'h0003) begin nerr++; $display("FAIL hb_hops: got %h want 0003", hops); end
      nvec++; if (e_max !== 16'h0400) begin nerr++; $display("FAIL hb_emax: got %h want 0400", e_max); end
      nvec++; if (e_min !== 16'h0100) begin nerr++; $display("FAIL hb_emin: got %h want 0100", e_min); end
      nvec++; if (e_threshold !== 16'h0080) begin nerr++; $display("FAIL hb_eth: got %h want 0080", e_threshold); end
      idle(1);
      nvec++; if (en_MNI !== 1'b0 || fPktType !== 3'b111) begin
         nerr++; $display("FAIL hb_pulse: en got %b type got %b want 0/111", en_MNI, fPktType);
      end
   endtask

   task automatic test_che();
      send_pkt('{16'h2003, 16'h0005, 16'h000C}, 2, 0);
      nvec++; if (en_MNI !== 1'b1) begin nerr++; $display("FAIL che_en: got %b want 1", en_MNI); end
      nvec++; if (fPktType !== 3'b001) begin nerr++; $display("FAIL che_type: got %b want 001", fPktType); end
      nvec++; if (ch_ID !== 16'h000C) begin nerr++; $display("FAIL che_ch: got %h want 000C", ch_ID); end
      nvec++; if (src_ID !== 16'h0005) begin nerr++; $display("FAIL che_src: got %h want 0005", src_ID); end
      nvec++; if (hops !== 16'h0003) begin nerr++; $display("FAIL che_hops_kept: got %h want 0003", hops); end
      idle(1);
   endtask

   task automatic test_dest_filter();
      int e0, p0;
      e0 = en_cnt; p0 = perr_cnt;
      send_pkt('{16'h8004, 16'h0006, 16'h0007, 16'h0011}, 3, 0);
      nvec++; if (fPktType !== 3'b111) begin nerr++; $display("FAIL ts_foreign_type: got %b want 111", fPktType); end
      idle(2);
      nvec++; if (en_cnt != e0 || perr_cnt != p0) begin
         nerr++; $display("FAIL ts_foreign_pulses: en %0d err %0d want 0 0", en_cnt - e0, perr_cnt - p0);
      end
      nvec++; if (timeslot !== 16'h0000) begin nerr++; $display("FAIL ts_foreign_ts: got %h want 0000", timeslot); end
      send_pkt('{16'h8004, 16'h0006, 16'hFFFF, 16'h0022}, 3, 0);
      nvec++; if (en_MNI !== 1'b1 || fPktType !== 3'b100) begin
         nerr++; $display("FAIL ts_bcast: en got %b type got %b want 1/100", en_MNI, fPktType);
      end
      nvec++; if (timeslot !== 16'h0022 || src_ID !== 16'h0006) begin
         nerr++; $display("FAIL ts_bcast_fields: ts %h src %h want 0022 0006", timeslot, src_ID);
      end
      idle(1);
      // DATA addressed to us, payload discarded, timeslot untouched
      send_pkt('{16'hA005, 16'h0008, 16'h000C, 16'h1234, 16'h5678}, 4, 0);
      nvec++; if (en_MNI !== 1'b1 || fPktType !== 3'b101) begin
         nerr++; $display("FAIL data_own: en got %b type got %b want 1/101", en_MNI, fPktType);
      end
      nvec++; if (src_ID !== 16'h0008 || timeslot !== 16'h0022 || ch_ID !== 16'h000C) begin
         nerr++; $display("FAIL data_fields: src %h ts %h ch %h want 0008 0022 000C", src_ID, timeslot, ch_ID);
      end
      idle(1);
   endtask

   task automatic test_errors();
      int e0;
      e0 = en_cnt;
      // Short HB: LEN=6, last on 4th word
      send_pkt('{16'h0006, 16'h0009, 16'h0009, 16'h0999}, 3, 0);
      nvec++; if (pkt_err !== 1'b1 || en_MNI !== 1'b0) begin
         nerr++; $display("FAIL short_hb: err got %b en got %b want 1/0", pkt_err, en_MNI);
      end
      nvec++; if (src_ID !== 16'h0008 || hops !== 16'h0003 || e_max !== 16'h0400) begin
         nerr++; $display("FAIL short_hb_kept: src %h hops %h emax %h want 0008 0003 0400", src_ID, hops, e_max);
      end
      idle(1);
      nvec++; if (pkt_err !== 1'b0) begin nerr++; $display("FAIL err_pulse: got %b want 0", pkt_err); end
      // Unknown type 010
      send_pkt('{16'h4003, 16'h1111, 16'h2222}, 2, 0);
      nvec++; if (pkt_err !== 1'b1 || fPktType !== 3'b111 || src_ID !== 16'h0008) begin
         nerr++; $display("FAIL unknown: err %b type %b src %h want 1 111 0008", pkt_err, fPktType, src_ID);
      end
      idle(1);
      // LEN 33 exceeds MAX_WORDS
      send_pkt('{16'h0021, 16'h0001}, 1, 0);
      nvec++; if (pkt_err !== 1'b1) begin nerr++; $display("FAIL len_big: got %b want 1", pkt_err); end
      idle(1);
      // CHE LEN=3 but 4 words
      send_pkt('{16'h2003, 16'h0001, 16'h0002, 16'h0003}, 3, 0);
      nvec++; if (pkt_err !== 1'b1 || ch_ID !== 16'h000C) begin
         nerr++; $display("FAIL long_che: err %b ch %h want 1 000C", pkt_err, ch_ID);
      end
      idle(1);
      // Header with in_last set
      send_pkt('{16'hC002}, 0, 0);
      nvec++; if (pkt_err !== 1'b1) begin nerr++; $display("FAIL hdr_last: got %b want 1", pkt_err); end
      idle(1);
      nvec++; if (en_cnt != e0) begin nerr++; $display("FAIL err_no_commit: en pulses %0d want 0", en_cnt - e0); end
   endtask

   task automatic test_hops_sat();
      send_pkt('{16'h0006, 16'h0004, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003}, 5, 2);
      nvec++; if (en_MNI !== 1'b1 || hops !== 16'hFFFF) begin
         nerr++; $display("FAIL hops_sat: en %b hops %h want 1 FFFF", en_MNI, hops);
      end
      nvec++; if (src_ID !== 16'h0004 || e_max !== 16'h0001 || e_min !== 16'h0002 || e_threshold !== 16'h0003) begin
         nerr++; $display("FAIL hops_sat_fields: %h %h %h %h want 0004 0001 0002 0003", src_ID, e_max, e_min, e_threshold);
      end
      idle(1);
      send_pkt('{16'h0006, 16'h0004, 16'hFFFE, 16'h0001, 16'h0002, 16'h0003}, 5, 0);
      nvec++; if (hops !== 16'hFFFF) begin nerr++; $display("FAIL hops_fffe: got %h want FFFF", hops); end
      idle(1);
   endtask

   task automatic test_back_to_back();
      put(16'h2003, 1'b0); put(16'h000A, 1'b0); put(16'h0033, 1'b1);
      nvec++; if (en_MNI !== 1'b1 || ch_ID !== 16'h0033) begin
         nerr++; $display("FAIL b2b_che: en %b ch %h want 1 0033", en_MNI, ch_ID);
      end
      put(16'hC002, 1'b0); put(16'h000B, 1'b1);
      nvec++; if (en_MNI !== 1'b1 || fPktType !== 3'b110 || src_ID !== 16'h000B) begin
         nerr++; $display("FAIL b2b_sos: en %b type %b src %h want 1 110 000B", en_MNI, fPktType, src_ID);
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      put(16'h0006, 1'b0); put(16'h0003, 1'b0); put(16'h0002, 1'b0);
      in_data = 16'h0400; in_valid = 1'b1;
      nrst = 1'b0;
      idle(1);
      nvec++; if (en_MNI !== 1'b0 || fPktType !== 3'b111 || in_ready !== 1'b1 || pkt_err !== 1'b0) begin
         nerr++; $display("FAIL midrst_ctl: en %b type %b rdy %b err %b want 0 111 1 0", en_MNI, fPktType, in_ready, pkt_err);
      end
      nvec++; if ({src_ID, hops, e_max, e_min, e_threshold, ch_ID, timeslot} !== 112'h0) begin
         nerr++; $display("FAIL midrst_fields: got %h want 0", {src_ID, hops, e_max, e_min, e_threshold, ch_ID, timeslot});
      end
      in_valid = 1'b0;
      nrst = 1'b1;
      idle(1);
      send_pkt('{16'hC002, 16'h0009}, 1, 0);
      nvec++; if (en_MNI !== 1'b1 || fPktType !== 3'b110 || src_ID !== 16'h0009 || hops !== 16'h0000) begin
         nerr++; $display("FAIL midrst_sos: en %b type %b src %h hops %h want 1 110 0009 0000", en_MNI, fPktType, src_ID, hops);
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_hb(0);
      test_che();
      test_dest_filter();
      test_errors();
      test_hops_sat();
      test_hb(3);
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
